seg_serial_display: RTL and testbench

Parametrised serial seven-segment display driver. It accepts an unsigned binary value on a load strobe and converts it to BCD sequentially (shift-and-add-3, one bit per cycle). It encodes each digit to a segment byte, shifts the bytes out on a serial data/clock pair, and finishes with a latch pulse. It replaces the fixed 4-digit combinational BCD / segment / LED-driver chain in the display path, and adds digit-count generalisation, leading-zero blanking, overflow indication and a busy/done handshake.

---
 rtl/seg_serial_display.sv | 194 +++++++++++++++++++
 tb/tb_seg_serial_display.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seg_serial_display.sv
// Serial seven-segment display driver.
// A loaded binary value is converted to BCD one bit per cycle (shift-and-add-3),
// each digit is encoded to a segment byte, the bytes are shifted out on a
// serial clock/data pair (most-significant digit first, MSB of each byte first),
// and the frame is closed with a latch pulse and a one-cycle done pulse.
//
// Handshake: i_load is a start strobe. It is accepted only on a rising edge
// where the FSM is in IDLE (the block is "ready" exactly when dbg_state is
// IDLE). i_data is sampled on that same edge. o_busy rises on the acceptance
// edge and falls when DONE exits. Strobes seen while busy are dropped, never
// queued.
module seg_serial_display #(
  parameter int DIGITS     = 4,
  parameter int BIN_W      = 13,
  parameter int CLK_DIV    = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int BLANK_LZ   = 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [BIN_W-1:0] i_data,
  input  logic             i_load,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic             o_SEGClk,
  output logic             o_SEGData,
  output logic             o_SEGLatch,
  output logic [2:0]       dbg_state
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SR_W   = 8 * DIGITS;
  localparam int CONV_W = $clog2(BIN_W + 1);
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int BIT_W  = $clog2(SR_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CONV  = 3'd1,
    S_ENC   = 3'd2,
    S_SHIFT = 3'd3,
    S_LATCH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   bin;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic               ovf;
  logic [CONV_W-1:0]  conv_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  // Holds the bits still to be sent after the one currently on o_SEGData.
  logic [SR_W-2:0]    sr;
  logic [SR_W-1:0]    enc_sr;
  logic               lead;
  logic [3:0]         nib;
  logic [7:0]         seg_byte;

  assign dbg_state = state;

  // Active-high segment pattern {dp,g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 8'h3F;
      4'd1:    seg_of = 8'h06;
      4'd2:    seg_of = 8'h5B;
      4'd3:    seg_of = 8'h4F;
      4'd4:    seg_of = 8'h66;
      4'd5:    seg_of = 8'h6D;
      4'd6:    seg_of = 8'h7D;
      4'd7:    seg_of = 8'h07;
      4'd8:    seg_of = 8'h7F;
      4'd9:    seg_of = 8'h6F;
      default: seg_of = 8'h00;
    endcase
  endfunction

  // Add-3 correction: every BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Segment frame: dashes on overflow, leading zeros blanked from the top
  // down (never the units digit), optional inversion applied last.
  always_comb begin
    enc_sr   = '0;
    lead     = 1'b1;
    nib      = 4'd0;
    seg_byte = 8'h00;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (ovf) seg_byte = 8'h40;
      else if ((BLANK_LZ != 0) && lead && (nib == 4'd0) && (i != 0)) seg_byte = 8'h00;
      else seg_byte = seg_of(nib);
      if (nib != 4'd0) lead = 1'b0;
      if (ACTIVE_LOW != 0) seg_byte = ~seg_byte;
      enc_sr[8*i +: 8] = seg_byte;
    end
  end

  // Main sequencer: conversion, encoding, serial shift, latch and done.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      bin        <= '0;
      bcd        <= '0;
      ovf        <= 1'b0;
      conv_cnt   <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
      o_SEGClk   <= 1'b0;
      o_SEGData  <= 1'b0;
      o_SEGLatch <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_load) begin
            bin      <= i_data;
            bcd      <= '0;
            ovf      <= 1'b0;
            conv_cnt <= '0;
            o_busy   <= 1'b1;
            state    <= S_CONV;
          end
        end
        S_CONV: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          // A bit leaving the top nibble means the value needs more digits.
          ovf <= ovf | bcd_adj[BCD_W-1];
          if (conv_cnt == CONV_W'(BIN_W - 1)) state <= S_ENC;
          else conv_cnt <= conv_cnt + 1'b1;
        end
        S_ENC: begin
          sr         <= enc_sr[SR_W-2:0];
          o_SEGData  <= enc_sr[SR_W-1];
          o_SEGClk   <= 1'b0;
          o_overflow <= ovf;
          div_cnt    <= '0;
          bit_cnt    <= '0;
          state      <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (!o_SEGClk) begin
              o_SEGClk <= 1'b1;
            end else begin
              // Falling edge of the serial clock: the only point data moves.
              o_SEGClk <= 1'b0;
              if (bit_cnt == BIT_W'(SR_W - 1)) begin
                o_SEGData  <= 1'b0;
                o_SEGLatch <= 1'b1;
                state      <= S_LATCH;
              end else begin
                o_SEGData <= sr[SR_W-2];
                sr        <= sr << 1;
                bit_cnt   <= bit_cnt + 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_LATCH: begin
          if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt    <= '0;
            o_SEGLatch <= 1'b0;
            o_done     <= 1'b1;
            state      <= S_DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_serial_display.sv
// Bench for seg_serial_display: four configurations share one clock and
// reset. Each frame's expected segment bytes come from a decimal model
// (division by powers of ten), queued and compared as bytes arrive serially.
module tb_seg_serial_display;

  // cfg 0: defaults; 1: no blanking; 2: 14-bit active-high; 3: 1 digit, div 1
  localparam int P_DIG [4] = '{4, 4, 4, 1};
  localparam int P_BW  [4] = '{13, 13, 14, 13};
  localparam int P_DIV [4] = '{4, 4, 4, 1};
  localparam int P_AL  [4] = '{1, 1, 0, 1};
  localparam int P_BLZ [4] = '{1, 0, 1, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] din = '0;
  logic [3:0]  load = '0;
  wire  [3:0]  busy, done, ovf, sclk, sdata, slatch;
  wire  [11:0] dbg_state;

  longint      cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  seg_tab [10];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    seg_serial_display #(
      .DIGITS(P_DIG[g]), .BIN_W(P_BW[g]), .CLK_DIV(P_DIV[g]),
      .ACTIVE_LOW(P_AL[g]), .BLANK_LZ(P_BLZ[g])
    ) u_dut (
      .clk(clk), .i_rst(rst), .i_data(din[P_BW[g]-1:0]), .i_load(load[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_overflow(ovf[g]),
      .o_SEGClk(sclk[g]), .o_SEGData(sdata[g]), .o_SEGLatch(slatch[g]),
      .dbg_state(dbg_state[3*g +: 3])
    );
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic int exp_latency(input int c);
    return P_BW[c] + 1 + 16 * P_DIG[c] * P_DIV[c] + P_DIV[c] + 1;
  endfunction

  // Queues the displayed bytes, most-significant digit first.
  task automatic build_expect(input int c, input int v, output bit ovf_e);
    logic [7:0] b;
    ovf_e = (v >= pow10(P_DIG[c]));
    for (int i = P_DIG[c] - 1; i >= 0; i--) begin
      if (ovf_e) b = 8'h40;
      else if (P_BLZ[c] != 0 && i > 0 && v < pow10(i)) b = 8'h00;
      else b = seg_tab[(v / pow10(i)) % 10];
      if (P_AL[c] != 0) b = ~b;
      exp_q.push_back(b);
    end
  endtask

  // ---------------- driver / monitor ----------------
  // inj=1 re-strobes i_load with 42 after the 10th serial clock rise.
  task automatic run_frame(input int c, input int v, input int inj);
    bit         ovf_e;
    int         rises = 0, lat_cyc = 0, lat_pulses = 0, viol = 0, nb = 0;
    int         lat = -1, busy_hi = 0, ndone = 0;
    logic       pc, pd, pl, cc, dd, ll;
    logic [7:0] acc = '0;
    longint     t0;
    bit         injected = 1'b0, load_hi = 1'b0;
    int         budget = exp_latency(c) + 40;

    exp_q.delete();
    build_expect(c, v, ovf_e);
    @(negedge clk);
    din = 14'(v); load[c] = 1'b1; t0 = cyc;
    @(negedge clk);
    load[c] = 1'b0; din = 14'($urandom);
    check("busy_after_accept", busy[c], 1);
    pc = sclk[c]; pd = sdata[c]; pl = slatch[c];
    for (int k = 0; k < budget && lat < 0; k++) begin
      @(negedge clk);
      if (load_hi) begin load[c] = 1'b0; load_hi = 1'b0; end
      cc = sclk[c]; dd = sdata[c]; ll = slatch[c];
      if (cc && !pc) begin
        if (dd !== pd) viol++;
        acc = {acc[6:0], dd};
        nb++; rises++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() > 0) check("seg_byte", acc, exp_q.pop_front());
        end
      end
      if (cc && pc && dd !== pd) viol++;
      if (ll) lat_cyc++;
      if (ll && !pl) lat_pulses++;
      if (ll && cc) viol++;
      if (done[c]) begin ndone++; lat = int'(cyc - t0); end
      if (inj == 1 && !injected && rises == 10) begin
        din = 14'd42; load[c] = 1'b1; load_hi = 1'b1; injected = 1'b1;
      end
      pc = cc; pd = dd; pl = ll;
    end
    check("latency", lat, exp_latency(c));
    check("overflow_flag", ovf[c], ovf_e);
    check("clk_rises", rises, 8 * P_DIG[c]);
    check("bytes_left", exp_q.size(), 0);
    check("latch_len", lat_cyc, P_DIV[c]);
    check("latch_pulses", lat_pulses, 1);
    check("serial_violations", viol, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy[c]) busy_hi++;
      if (done[c]) ndone++;
    end
    check("done_pulses", ndone, 1);
    check("busy_after_done", busy_hi, 0);
  endtask

  // Starts a frame, asserts reset after the 10th serial rise, checks the abort.
  task automatic abort_frame(input int c, input int v);
    int   rises = 0, lat_after = 0, done_after = 0;
    logic pc;
    @(negedge clk);
    din = 14'(v); load[c] = 1'b1;
    @(negedge clk);
    load[c] = 1'b0;
    pc = sclk[c];
    for (int k = 0; k < exp_latency(c) && rises < 10; k++) begin
      @(negedge clk);
      if (sclk[c] && !pc) rises++;
      pc = sclk[c];
    end
    check("abort_reached_bit10", rises, 10);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {busy[c], done[c], ovf[c], sclk[c], sdata[c], slatch[c]}, 0);
    rst = 1'b0;
    for (int k = 0; k < exp_latency(c) + 20; k++) begin
      @(negedge clk);
      if (slatch[c]) lat_after++;
      if (done[c] || busy[c]) done_after++;
    end
    check("abort_no_latch", lat_after, 0);
    check("abort_no_activity", done_after, 0);
  endtask

  // ---------------- stimulus + report ----------------
  initial begin
    int v;
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, ovf, sclk, sdata, slatch}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_outputs", {busy, done, ovf, sclk, sdata, slatch}, 0);

    run_frame(0, 1234, 0);
    run_frame(0, 0, 0);
    run_frame(1, 0, 0);
    run_frame(2, 12345, 0);
    run_frame(2, 9999, 0);
    run_frame(0, 7, 1);
    abort_frame(0, 1234);
    run_frame(0, 56, 0);
    run_frame(3, 8, 0);
    run_frame(0, 8191, 0);
    run_frame(2, 10000, 0);

    for (int n = 0; n < 4; n++) begin
      v = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 120) : $urandom_range(0, 8191);
      run_frame(0, v, 0);
      v = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 120) : $urandom_range(0, 8191);
      run_frame(1, v, 0);
      run_frame(2, $urandom_range(0, 16383), 0);
      run_frame(3, $urandom_range(0, 12), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
